// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes and datapath select values.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRLINK = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Dispatch out of DECODE; unsupported funct3 values trap here rather than later.
    function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] funct3);
        state_t ns;
        case (op)
            OP_LOAD, OP_STORE: ns = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
            OP_R:              ns = (funct3 == 3'b011) ? S_TRAP : S_EXECUTER;
            OP_I:              ns = (funct3 == 3'b011) ? S_TRAP : S_EXECUTEI;
            OP_BRANCH:         ns = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
            OP_JAL:            ns = S_JAL;
            OP_JALR:           ns = S_JALR;
            default:           ns = S_TRAP;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps ALUOp plus instruction fields to the 3-bit ALU operation code.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       opb5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type can subtract; addi leaves bit 30 as immediate data.
                    3'b000:  alucontrol = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alucontrol = ALU_SLL;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b100:  alucontrol = ALU_XOR;
                    3'b101:  alucontrol = ALU_SRL;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: instruction-sequencing Moore FSM, immediate
// format decode and ALU decode driving every datapath select and enable.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic [1:0]         immsrc,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         resultsrc,
    output logic               adrsrc,
    output logic [2:0]         alucontrol,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               regwrite,
    output logic               memwrite,
    output logic               illegal,
    output logic               retire,
    output logic [STATE_W-1:0] state_o
);

    state_t     state, next_state;
    logic [1:0] aluop;
    logic       pcupdate;
    logic       branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        aluop      = ALUOP_ADD;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_WD;
        resultsrc  = RES_ALUOUT;
        adrsrc     = 1'b0;
        irwrite    = 1'b0;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                irwrite    = 1'b1;
                alusrcb    = SRCB_FOUR;
                resultsrc  = RES_ALURESULT;
                pcupdate   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_IMM;
                next_state = decode_next(op, funct3);
            end
            S_MEMADR: begin
                alusrca    = SRCA_REG;
                alusrcb    = SRCB_IMM;
                next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc = RES_DATA;
                regwrite  = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                retire   = 1'b1;
            end
            S_EXECUTER: begin
                alusrca    = SRCA_REG;
                alusrcb    = SRCB_WD;
                aluop      = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca    = SRCA_REG;
                alusrcb    = SRCB_IMM;
                aluop      = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                alusrca = SRCA_REG;
                alusrcb = SRCB_WD;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                retire  = 1'b1;
            end
            // Target already sits in ALUOut from DECODE; this cycle forms the link value.
            S_JAL: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                pcupdate   = 1'b1;
                next_state = S_ALUWB;
            end
            S_JALR: begin
                alusrca    = SRCA_REG;
                alusrcb    = SRCB_IMM;
                resultsrc  = RES_ALURESULT;
                pcupdate   = 1'b1;
                next_state = S_JALRLINK;
            end
            S_JALRLINK: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                next_state = S_ALUWB;
            end
            S_TRAP: begin
                illegal    = 1'b1;
                next_state = S_TRAP;
            end
            default: begin
                illegal    = 1'b1;
                next_state = S_FETCH;
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_I, OP_JALR: immsrc = IMM_I;
            OP_STORE:               immsrc = IMM_S;
            OP_BRANCH:              immsrc = IMM_B;
            OP_JAL:                 immsrc = IMM_J;
            default:                immsrc = IMM_I;
        endcase
    end

    // bne reuses the beq comparison with the sense flipped by funct3[0].
    assign pcwrite = pcupdate | (branch & (zero ^ funct3[0]));
    assign state_o = STATE_W'(state);

    mc_alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .opb5       (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite, pcwrite, regwrite, memwrite, illegal, retire;
    logic [3:0] state_o;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_JALR = 6, C_ILL = 7;

    int exp_q[$];
    int exp_cls;

    always #5 clk = ~clk;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .adrsrc     (adrsrc),
        .alucontrol (alucontrol),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .illegal    (illegal),
        .retire     (retire),
        .state_o    (state_o)
    );

    // Instruction-level model: classify the instruction, then list the states it visits.
    function automatic void build_expected(input logic [6:0] o, input logic [2:0] f3);
        case (o)
            7'b0000011: exp_cls = (f3 == 3'b010) ? C_LW : C_ILL;
            7'b0100011: exp_cls = (f3 == 3'b010) ? C_SW : C_ILL;
            7'b0110011: exp_cls = (f3 != 3'b011) ? C_R : C_ILL;
            7'b0010011: exp_cls = (f3 != 3'b011) ? C_I : C_ILL;
            7'b1100011: exp_cls = (f3 == 3'b000 || f3 == 3'b001) ? C_BR : C_ILL;
            7'b1101111: exp_cls = C_JAL;
            7'b1100111: exp_cls = C_JALR;
            default:    exp_cls = C_ILL;
        endcase
        exp_q = {0, 1};
        case (exp_cls)
            C_LW:    exp_q = {exp_q, 2, 3, 4};
            C_SW:    exp_q = {exp_q, 2, 5};
            C_R:     exp_q = {exp_q, 6, 8};
            C_I:     exp_q = {exp_q, 7, 8};
            C_BR:    exp_q = {exp_q, 9};
            C_JAL:   exp_q = {exp_q, 10, 8};
            C_JALR:  exp_q = {exp_q, 11, 12, 8};
            default: exp_q = {exp_q, 13};
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'd1:    return 3'b110;
            3'd2:    return 3'b101;
            3'd4:    return 3'b100;
            3'd5:    return 3'b111;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Call just after a falling edge with the FSM in FETCH; returns the same way.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zsel);
        int   len;
        logic last, taken, e_pc, e_rw;
        logic [2:0] e_alu;
        op = o; funct3 = f3; funct7b5 = f7;
        build_expected(o, f3);
        len = exp_q.size();
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : zsel[0];
            #1;
            last  = (c == len - 1);
            taken = (f3[0] == 1'b0) ? zero : !zero;
            e_pc  = (c == 0) || (c == 2 && (exp_cls == C_JAL || exp_cls == C_JALR)) ||
                    (c == 2 && exp_cls == C_BR && taken);
            e_rw  = last && (exp_cls == C_LW || exp_cls == C_R || exp_cls == C_I ||
                             exp_cls == C_JAL || exp_cls == C_JALR);
            n_cmp++; if (state_o !== exp_q[c][3:0]) begin n_fail++;
                $display("[TB] FAIL state op=%b c=%0d got=%0d exp=%0d", o, c, state_o, exp_q[c]); end
            n_cmp++; if (pcwrite !== e_pc) begin n_fail++;
                $display("[TB] FAIL pcwrite op=%b c=%0d zero=%b got=%b exp=%b", o, c, zero, pcwrite, e_pc); end
            n_cmp++; if (regwrite !== e_rw) begin n_fail++;
                $display("[TB] FAIL regwrite op=%b c=%0d got=%b exp=%b", o, c, regwrite, e_rw); end
            n_cmp++; if (memwrite !== (last && exp_cls == C_SW)) begin n_fail++;
                $display("[TB] FAIL memwrite op=%b c=%0d got=%b", o, c, memwrite); end
            n_cmp++; if (irwrite !== (c == 0)) begin n_fail++;
                $display("[TB] FAIL irwrite op=%b c=%0d got=%b", o, c, irwrite); end
            n_cmp++; if (retire !== (last && exp_cls != C_ILL)) begin n_fail++;
                $display("[TB] FAIL retire op=%b c=%0d got=%b", o, c, retire); end
            n_cmp++; if (illegal !== (exp_cls == C_ILL && last)) begin n_fail++;
                $display("[TB] FAIL illegal op=%b c=%0d got=%b", o, c, illegal); end
            n_cmp++; if (immsrc !== exp_imm(o)) begin n_fail++;
                $display("[TB] FAIL immsrc op=%b got=%b exp=%b", o, immsrc, exp_imm(o)); end
            n_cmp++; if (adrsrc !== (c == 3 && (exp_cls == C_LW || exp_cls == C_SW))) begin n_fail++;
                $display("[TB] FAIL adrsrc op=%b c=%0d got=%b", o, c, adrsrc); end
            if (c == 0) begin
                n_cmp++; if (alusrcb !== 2'b10 || resultsrc !== 2'b10 || alusrca !== 2'b00) begin n_fail++;
                    $display("[TB] FAIL fetch_sel got a=%b b=%b r=%b exp a=00 b=10 r=10", alusrca, alusrcb, resultsrc); end
            end
            if (c == 1) begin
                n_cmp++; if (alusrca !== 2'b01 || alusrcb !== 2'b01) begin n_fail++;
                    $display("[TB] FAIL decode_sel got a=%b b=%b exp a=01 b=01", alusrca, alusrcb); end
            end
            if (last && exp_cls != C_ILL) begin
                n_cmp++; if (resultsrc !== ((exp_cls == C_LW) ? 2'b01 : 2'b00)) begin n_fail++;
                    $display("[TB] FAIL wb_resultsrc op=%b got=%b", o, resultsrc); end
            end
            e_alu = 3'b000;
            if (c == 2 && (exp_cls == C_R || exp_cls == C_I)) e_alu = exp_alu(o, f3, f7);
            if (c == 2 && exp_cls == C_BR) e_alu = 3'b001;
            n_cmp++; if (alucontrol !== e_alu) begin n_fail++;
                $display("[TB] FAIL alucontrol op=%b f3=%b f7=%b c=%0d got=%b exp=%b", o, f3, f7, c, alucontrol, e_alu); end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset_and_release();
        reset = 1'b1;
        #1;
        n_cmp++; if (state_o !== 4'd0) begin n_fail++;
            $display("[TB] FAIL async_reset got=%0d exp=0", state_o); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_state got=%0d exp=0", state_o); end
        n_cmp++; if ({irwrite, pcwrite, regwrite, memwrite, illegal, retire, adrsrc} !== 7'b1100000) begin n_fail++;
            $display("[TB] FAIL reset_enables got=%b exp=1100000",
                     {irwrite, pcwrite, regwrite, memwrite, illegal, retire, adrsrc}); end
        n_cmp++; if (alusrcb !== 2'b10 || resultsrc !== 2'b10 || alucontrol !== 3'b000) begin n_fail++;
            $display("[TB] FAIL reset_sel got b=%b r=%b alu=%b exp b=10 r=10 alu=000", alusrcb, resultsrc, alucontrol); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (state_o !== 4'd3) begin n_fail++; $display("[TB] FAIL mid_memread got=%0d exp=3", state_o); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (state_o !== 4'd0 || regwrite !== 1'b0) begin n_fail++;
            $display("[TB] FAIL mid_reset got state=%0d regwrite=%b exp state=0 regwrite=0", state_o, regwrite); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (irwrite !== 1'b1 || pcwrite !== 1'b1 || alusrcb !== 2'b10 || resultsrc !== 2'b10) begin n_fail++;
            $display("[TB] FAIL post_reset got ir=%b pc=%b b=%b r=%b exp ir=1 pc=1 b=10 r=10",
                     irwrite, pcwrite, alusrcb, resultsrc); end
        run_instr(7'b0010011, 3'b000, 1'b0, -1);
    endtask

    task automatic test_lw_sw();
        run_instr(7'b0000011, 3'b010, 1'b0, -1);
        run_instr(7'b0100011, 3'b010, 1'b1, -1);
    endtask

    task automatic test_alu_decode();
        run_instr(7'b0110011, 3'b000, 1'b1, -1);
        run_instr(7'b0010011, 3'b000, 1'b1, -1);
        run_instr(7'b0110011, 3'b101, 1'b0, -1);
        run_instr(7'b0110011, 3'b111, 1'b0, -1);
    endtask

    task automatic test_branch();
        for (int f = 0; f < 2; f++)
            for (int z = 0; z < 2; z++)
                run_instr(7'b1100011, 3'(f), 1'b0, z);
    endtask

    task automatic test_jumps();
        run_instr(7'b1101111, 3'($urandom_range(0, 7)), 1'b0, -1);
        run_instr(7'b1100111, 3'b000, 1'b0, -1);
    endtask

    task automatic test_illegal(input logic [6:0] o, input logic [2:0] f3);
        run_instr(o, f3, 1'b0, -1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            zero = 1'($urandom_range(0, 1));
            #1;
            n_cmp++; if (state_o !== 4'd13 || illegal !== 1'b1) begin n_fail++;
                $display("[TB] FAIL trap_hold c=%0d got state=%0d illegal=%b exp 13/1", c, state_o, illegal); end
            n_cmp++; if ({irwrite, pcwrite, regwrite, memwrite, retire} !== 5'b0) begin n_fail++;
                $display("[TB] FAIL trap_enables c=%0d got=%b exp=00000",
                         c, {irwrite, pcwrite, regwrite, memwrite, retire}); end
        end
        apply_reset_and_release();
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [7];
        logic [6:0] o;
        logic [2:0] f3;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111};
        for (int i = 0; i < 60; i++) begin
            o  = ops[$urandom_range(0, 6)];
            f3 = 3'($urandom_range(0, 7));
            if (o == 7'b0000011 || o == 7'b0100011) f3 = 3'b010;
            if (o == 7'b1100011) f3 = {2'b00, f3[0]};
            if ((o == 7'b0110011 || o == 7'b0010011) && f3 == 3'b011) f3 = 3'b000;
            if ($urandom_range(0, 19) == 0) begin
                o = 7'($urandom_range(0, 127));
                build_expected(o, f3);
                if (exp_cls == C_ILL) test_illegal(o, f3);
                else run_instr(o, f3, 1'($urandom_range(0, 1)), -1);
            end else begin
                run_instr(o, f3, 1'($urandom_range(0, 1)), -1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw_sw();
        test_reset_mid();
        test_alu_decode();
        test_branch();
        test_jumps();
        test_illegal(7'b0110111, 3'b000);
        test_illegal(7'b0110011, 3'b011);
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Control unit for the multicycle RV32I core. It sits directly upstream of the datapath and drives every datapath select and enable.
- Inputs are the latched instruction fields (op, funct3, funct7 bit 5) and the ALU zero flag.
- Contains the main instruction-sequencing FSM, an ALU decoder and an immediate-format decoder.
- Supports lw, sw, R-type, I-type ALU, beq/bne, jal and jalr. Any other encoding traps to an illegal-instruction state.

Parameters:
- STATE_W, 4, width of the state register and the debug state port.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  7  instruction bits 6:0 from the instruction register.
- funct3  in  3  instruction bits 14:12.
- funct7b5  in  1  instruction bit 30.
- zero  in  1  ALU result == 0.
- immsrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- alusrca  out  2  ALU A select: 00 PC, 01 OldPC, 10 A register.
- alusrcb  out  2  ALU B select: 00 WriteData register, 01 ImmExt, 10 constant 4.
- resultsrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
- adrsrc  out  1  memory address select: 0 PC, 1 Result.
- alucontrol  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- irwrite  out  1  latch instruction and OldPC.
- pcwrite  out  1  PC enable; internally the OR of the unconditional update and (branch & taken).
- regwrite  out  1  register file write enable.
- memwrite  out  1  data memory write enable.
- illegal  out  1  high while in TRAP.
- retire  out  1  high in the final cycle of each instruction.
- state_o  out  STATE_W  current state, for debug.

Behaviour:
- Moore FSM. All outputs are combinational from the state, except: immsrc (from op); alucontrol (from ALUOp, funct3, op[5] and funct7b5); pcwrite in BRANCH (depends on zero). Any output not listed for a state is 0.
- Reset: state goes to FETCH asynchronously; state_o = 0. While reset is held, the outputs are the FETCH values. Reset in the middle of an instruction abandons it; no further writes come from that instruction.
- ALUOp drives alucontrol as follows:
  - ALUOp 00: add. ALUOp 01: sub.
  - ALUOp 10: decode funct3. 000 gives sub if op[5] & funct7b5, otherwise add. 001 sll, 010 slt, 100 xor, 101 srl, 110 or, 111 and.
- immsrc by opcode: I for load, I-type ALU and jalr; S for store; B for branch; J for jal; 00 for anything else.
- States and transitions:
  - FETCH (0): adrsrc 0, irwrite 1, alusrca 00, alusrcb 10, add, resultsrc 10, pcwrite 1. Next: DECODE.
  - DECODE (1): alusrca 01, alusrcb 01, add; this computes OldPC+imm into ALUOut. Next by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - otherwise → TRAP
    - Also → TRAP if: load/store with funct3 != 010; branch with funct3 not 000/001; R-type or I-type with funct3 011.
  - MEMADR (2): alusrca 10, alusrcb 01, add. Next: MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
  - MEMREAD (3): resultsrc 00, adrsrc 1. Next: MEMWB.
  - MEMWB (4): resultsrc 01, regwrite, retire. Next: FETCH.
  - MEMWRITE (5): resultsrc 00, adrsrc 1, memwrite, retire. Next: FETCH.
  - EXECUTER (6): alusrca 10, alusrcb 00, ALUOp 10. Next: ALUWB.
  - EXECUTEI (7): alusrca 10, alusrcb 01, ALUOp 10. Next: ALUWB.
  - ALUWB (8): resultsrc 00, regwrite, retire. Next: FETCH.
  - BRANCH (9): alusrca 10, alusrcb 00, ALUOp 01, resultsrc 00, retire. pcwrite = zero ^ funct3[0]. Next: FETCH.
  - JAL (10): alusrca 01, alusrcb 10, add, resultsrc 00, pcwrite. The PC takes the target held in ALUOut; ALUOut captures OldPC+4. Next: ALUWB.
  - JALR (11): alusrca 10, alusrcb 01, add, resultsrc 10, pcwrite. PC = rs1+imm; bit 0 is not cleared. Next: JALRLINK.
  - JALRLINK (12): alusrca 01, alusrcb 10, add. Next: ALUWB.
  - TRAP (13): all enables 0, illegal 1. Stays in TRAP until reset.
- Latency in cycles, FETCH through retire: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5.
- Unused encodings 14–15: next state is FETCH; outputs are as in TRAP.

Decomposition:
- Package mc_ctrl_pkg holds:
  - a state enum with the encodings 0–13 above;
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR;
  - ALUOp and alucontrol localparams;
  - select-encoding constants for alusrca, alusrcb, resultsrc and immsrc.
- Sub-module mc_alu_decoder (combinational: ALUOp, funct3, op[5], funct7b5 → alucontrol). The FSM and the immsrc decoding stay in the top module.

Test Plan:
- Reset mid-instruction: assert reset during MEMREAD of a lw (op 0000011, funct3 010) → state_o=0 immediately; after release: irwrite=1, pcwrite=1, alusrcb=10, resultsrc=10.
- lw: op 0000011, funct3 010 → state sequence 0,1,2,3,4; memwrite never 1; regwrite=1 and retire=1 only in state 4, with resultsrc=01.
- sub/srl/and:
  - R-type sub: op 0110011, funct3 000, funct7b5 1 → alucontrol 001 in EXECUTER.
  - Same encoding with op 0010011 (addi) → alucontrol 000.
  - funct3 101 → 111; funct3 111 → 010.
- Branch outcome:
  - beq: funct3 000 with zero=1 → pcwrite=1 in BRANCH; with zero=0 → pcwrite=0.
  - bne: funct3 001 inverts both results.
  - Next state is FETCH in every case.
- jal and jalr:
  - jal (1101111): states 0,1,10,8; immsrc=11; pcwrite=1 in state 10; regwrite=1 in state 8.
  - jalr (1100111): states 0,1,11,12,8; pcwrite only in state 11.
- Illegal encodings: op 0110111 (lui), or op 0110011 with funct3 011, → state 13; illegal=1 and all enables 0 for 10+ cycles; cleared only by reset.
